// File: rtl/md_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: operation codes and
// sequencer states, plus a helper that classifies the multi-cycle operations.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // MULT/MULTU/DIV/DIVU occupy the unit for several cycles.
  function automatic logic md_is_long(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: 64-bit {HI, LO} result for the
// requested operation plus a divide-by-zero flag.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div_zero
);

  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] divisor;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  // Signed divide works on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
  assign a_neg   = (op == MD_DIV) && a[31];
  assign b_neg   = (op == MD_DIV) && b[31];
  assign abs_a   = a_neg ? (~a + 32'd1) : a;
  assign abs_b   = b_neg ? (~b + 32'd1) : b;
  assign divisor = (b == '0) ? 32'd1 : abs_b;
  assign quo     = abs_a / divisor;
  assign rem     = abs_a % divisor;
  assign quo_s   = (a_neg ^ b_neg) ? (~quo + 32'd1) : quo;
  assign rem_s   = a_neg ? (~rem + 32'd1) : rem;

  always_comb begin
    res      = '0;
    div_zero = 1'b0;
    case (op)
      MD_MULT:  res = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      MD_MULTU: res = {32'd0, a} * {32'd0, b};
      MD_DIV, MD_DIVU: begin
        res      = {rem_s, quo_s};
        div_zero = (b == '0);
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide controller: owns HI/LO, models fixed multi-cycle
// latency with a down-counter, and requests D/E stalls for dependent md ops.
module md_sequencer
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_o
);

  md_state_e   state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] p_hi, p_hi_n;
  logic [31:0] p_lo, p_lo_n;
  logic        p_dz, p_dz_n;
  logic [31:0] hi_n, lo_n;
  logic [63:0] res;
  logic        div_zero;
  logic        long_start;

  md_arith u_arith (
    .op       (md_op),
    .a        (a),
    .b        (b),
    .res      (res),
    .div_zero (div_zero)
  );

  assign long_start = start && md_is_long(md_op);
  assign busy       = (state == ST_RUN);
  assign stall      = d_md_use && (busy || long_start);

  always_comb begin
    mf_o = '0;
    if (md_op == MD_MFHI)      mf_o = hi;
    else if (md_op == MD_MFLO) mf_o = lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      p_dz  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      p_hi  <= p_hi_n;
      p_lo  <= p_lo_n;
      p_dz  <= p_dz_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    p_hi_n  = p_hi;
    p_lo_n  = p_lo;
    p_dz_n  = p_dz;
    case (state)
      ST_IDLE: begin
        if (long_start) begin
          p_hi_n  = res[63:32];
          p_lo_n  = res[31:0];
          p_dz_n  = div_zero;
          cnt_n   = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ?
                    4'(MULT_CYCLES - 1) : 4'(DIV_CYCLES - 1);
          state_n = ST_RUN;
        end else if (start && (md_op == MD_MTHI)) begin
          hi_n = a;
        end else if (start && (md_op == MD_MTLO)) begin
          lo_n = a;
        end
      end
      ST_RUN: begin
        // Divide-by-zero burns the full latency but leaves HI/LO untouched.
        if (cnt == '0) begin
          state_n = ST_IDLE;
          if (!p_dz) begin
            hi_n = p_hi;
            lo_n = p_lo;
          end
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: expected HI/LO queued at issue, compared
// at commit; busy length and stall behaviour checked cycle by cycle.
module tb_md_sequencer;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo),
    .mf_o     (mf_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    assert (!(busy && start)) else $error("start issued while busy");

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (op)
      MD_MULT:  return 64'(sx * sy);
      MD_MULTU: return ux * uy;
      MD_DIV: begin
        if (y == '0) return {m_hi, m_lo};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      MD_DIVU: begin
        if (y == '0) return {m_hi, m_lo};
        return {x % y, x / y};
      end
      default: return {m_hi, m_lo};
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_long(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic dmd, input int unsigned ncyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int unsigned nb;
    logic [63:0] e;
    exp_q.push_back({exp_hi, exp_lo});
    start = 1'b1; md_op = op; a = va; b = vb; d_md_use = dmd;
    @(negedge clk);
    check("stall_issue", 32'(stall), 32'(dmd));
    check("busy_issue", 32'(busy), 32'd0);
    next_cycle();
    start = 1'b0; md_op = MD_NONE; a = '0; b = '0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      check("stall_busy", 32'(stall), 32'(dmd));
      if (nb == 1) check("hi_hold", hi, m_hi);
      next_cycle();
    end
    check("busy_len", nb, ncyc);
    check("stall_after", 32'(stall), 32'd0);
    e = exp_q.pop_front();
    check("hi_commit", hi, e[63:32]);
    check("lo_commit", lo, e[31:0]);
    m_hi = e[63:32];
    m_lo = e[31:0];
    next_cycle();
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] v);
    start = 1'b1; md_op = op; a = v; d_md_use = 1'b0;
    next_cycle();
    start = 1'b0; md_op = MD_NONE; a = '0;
    if (op == MD_MTHI) m_hi = v; else m_lo = v;
    @(negedge clk);
    check("mt_busy", 32'(busy), 32'd0);
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
    next_cycle();
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] e;
    reset = 1'b1; start = 1'b0; md_op = MD_NONE; a = '0; b = '0; d_md_use = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    next_cycle();

    do_long(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    do_long(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5, 32'hFFFF_FFFE, 32'h0000_0001);

    // the stalled MFHI now reaches E
    start = 1'b1; md_op = MD_MFHI; d_md_use = 1'b0;
    @(negedge clk);
    check("mfhi", mf_o, 32'hFFFF_FFFE);
    check("mf_stall", 32'(stall), 32'd0);
    md_op = MD_MFLO;
    #1;
    check("mflo", mf_o, 32'h0000_0001);
    md_op = MD_NONE;
    #1;
    check("mf_none", mf_o, 32'd0);
    next_cycle();
    start = 1'b0;

    do_long(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_long(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 32'd0, 32'h8000_0000);
    do_mt(MD_MTLO, 32'hCAFE_F00D);
    do_mt(MD_MTHI, 32'h1234_5678);
    do_long(MD_DIVU, 32'h0000_0064, 32'd0, 1'b1, 10, 32'h1234_5678, 32'hCAFE_F00D);

    for (int unsigned k = 0; k < 4; k++) begin
      rop = 4'(1 + (k % 4));
      ra  = $urandom;
      rb  = (k == 3) ? 32'($urandom_range(1, 9)) : $urandom;
      e   = model(rop, ra, rb);
      do_long(rop, ra, rb, k[0], (rop <= MD_MULTU) ? 5 : 10, e[63:32], e[31:0]);
    end

    // reset during the 4th busy cycle of a divide
    start = 1'b1; md_op = MD_DIV; a = 32'd100; b = 32'd7; d_md_use = 1'b1;
    next_cycle();
    start = 1'b0; md_op = MD_NONE;
    for (int i = 0; i < 3; i++) next_cycle();
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_hi", hi, 32'd0);
    check("mid_rst_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) next_cycle();
    @(negedge clk);
    check("no_commit_hi", hi, 32'd0);
    check("no_commit_lo", lo, 32'd0);
    check("no_commit_busy", 32'(busy), 32'd0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multiply/divide controller for the five-stage MIPS pipeline, sitting in E beside the ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests from the E stage and owns the HI/LO registers. It models the fixed multi-cycle latency with a busy counter and raises a stall request that freezes the D/E pipeline registers. MFHI/MFLO read data feeds the E-stage result mux into the E→M register.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1–15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1–15)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  valid md_op in the E stage this cycle
- md_op  in  4  operation code (md_pkg encoding)
- a  in  32  rs operand (forwarded)
- b  in  32  rt operand (forwarded)
- d_md_use  in  1  instruction in D is any md_pkg op other than MD_NONE
- busy  out  1  multi-cycle operation in progress
- stall  out  1  stall request to the PC, D and E registers (hold D, bubble E)
- hi  out  32  current HI
- lo  out  32  current LO
- mf_o  out  32  HI if md_op==MD_MFHI, LO if md_op==MD_MFLO, else 0 (combinational)

## Operation
- States: IDLE, RUN; 4-bit down-counter cnt; 32-bit pending registers p_hi, p_lo.
- IDLE, start with MULT/MULTU/DIV/DIVU:
  - compute the result in the same cycle and latch it into p_hi/p_lo;
  - load cnt = MULT_CYCLES-1 or DIV_CYCLES-1; go to RUN.
- RUN: cnt decrements each cycle. At cnt==0, commit p_hi→HI and p_lo→LO on that edge, then return to IDLE.
- MULT: signed 64-bit product. MULTU: unsigned product. HI = bits [63:32], LO = bits [31:0].
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): LO = 0x80000000, HI = 0.
- Divide by zero (b==0): still occupies DIV_CYCLES busy cycles; HI/LO left unchanged at commit.
- MTHI/MTLO with start in IDLE: write a to HI/LO on that edge; no busy.
- MFHI/MFLO: no state change; value is available on mf_o.
- start while busy: ignored. The stall logic guarantees it never occurs; the bench asserts it.
- busy = (state==RUN).
- stall = d_md_use & (busy | (start & md_op ∈ {MULT, MULTU, DIV, DIVU})).
- Reset: state IDLE, cnt 0, HI=LO=p_hi=p_lo=0, busy=0, stall=0. Reset mid-RUN discards the pending result.

## Timing
- start in cycle T with MULT: busy high in cycles T+1..T+5 (exactly MULT_CYCLES cycles); new HI/LO visible from T+6.
- DIV: busy high in T+1..T+10; HI/LO updated from T+11.
- MTHI/MTLO at T: HI/LO updated from T+1.
- An MFHI in D during T..T+N is stalled and enters E in cycle T+N+1, reading the committed value.
- Back-to-back: a new start is accepted in the first IDLE cycle after commit.
- A non-md instruction in D never stalls, even when busy.

## Structure
- md_pkg holds:
  - op localparams: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MFHI=7, MD_MFLO=8;
  - state encodings ST_IDLE=0, ST_RUN=1.
- One sub-module, md_arith: purely combinational 64-bit result from op/a/b, including the div-by-zero flag. md_sequencer holds the FSM, counter, HI/LO and stall logic.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 → busy for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; MFHI in D stalled for 6 cycles (start cycle plus 5 busy), then mf_o=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → busy for 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678, then DIVU b=0 → busy for 10 cycles, hi stays 0x12345678, lo unchanged.
- Reset in the 4th busy cycle of DIV → next cycle busy=0, stall=0, hi=lo=0; no later commit.
- Non-md instruction in D while busy → stall=0. d_md_use=1 while busy → stall=1 every busy cycle, dropping in the cycle after commit.
